// File: rtl/muldiv_ctrl.sv
//------------------------------------------------------------------------------
// muldiv_ctrl
//
// Sequencing controller for the EXE-stage multiply/divide resource.
// It issues operations from EXE to an external pipelined multiplier and an
// external iterative divider. It latches their operands and stalls EXE while
// work is in flight. It does the 64-bit HI/LO accumulate for MADD/MSUB itself
// and owns the HI/LO write port. An exception flush cancels in-flight work.
//
// Parameters
//   MUL_LAT     multiplier latency in cycles (1..7)
//
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   ex_valid, ex_op         EXE holds an instruction / its operation code
//   ex_flush                exception flush, aborts the current operation
//   ex_srca, ex_srcb        forwarded rs / rt operands
//   op_a, op_b              operands latched at issue
//   mul_start, mul_signed   multiplier issue pulse and signedness
//   mul_res                 product, valid MUL_LAT cycles after mul_start
//   div_start, div_signed   divider issue pulse and signedness
//   div_abort               one-cycle divider cancel
//   div_done, div_quot,
//   div_rem                 divider completion and results
//   hi_q, lo_q              current HI/LO contents
//   hi_we, lo_we,
//   hi_wdata, lo_wdata      HI/LO write port
//   ex_stall                hold the EXE stage
//   busy                    controller is not idle
//------------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic        ex_flush,
    input  logic [31:0] ex_srca,
    input  logic [31:0] ex_srcb,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        mul_start,
    output logic        mul_signed,
    input  logic [63:0] mul_res,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_abort,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    input  logic [31:0] hi_q,
    input  logic [31:0] lo_q,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        ex_stall,
    output logic        busy
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        ACC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opA_q, opA_d;
    logic [31:0]        opB_q, opB_d;
    logic [63:0]        prod_q, prod_d;
    logic [63:0]        res_q, res_d;
    logic               isAcc_q, isAcc_d;
    logic               isSub_q, isSub_d;

    // Unqualified versions of the outputs; they are forced to zero while
    // resetn is low so the block looks fully idle during reset.
    logic               mulStart, mulSigned;
    logic               divStart, divSigned, divAbort;
    logic               hiWe, loWe;
    logic [31:0]        hiWdata, loWdata;
    logic               stall;

    logic               opSigned;
    logic [63:0]        hiLo;

    assign opSigned = (ex_op == OP_MULT) || (ex_op == OP_MADD) ||
                      (ex_op == OP_MSUB) || (ex_op == OP_DIV);
    assign hiLo     = {hi_q, lo_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            isAcc_q <= 1'b0;
            isSub_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            isAcc_q <= isAcc_d;
            isSub_q <= isSub_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        prod_d    = prod_q;
        res_d     = res_q;
        isAcc_d   = isAcc_q;
        isSub_d   = isSub_q;
        mulStart  = 1'b0;
        mulSigned = 1'b0;
        divStart  = 1'b0;
        divSigned = 1'b0;
        divAbort  = 1'b0;
        hiWe      = 1'b0;
        loWe      = 1'b0;
        hiWdata   = '0;
        loWdata   = '0;
        stall     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid && !ex_flush) begin
                    case (ex_op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            opA_d     = ex_srca;
                            opB_d     = ex_srcb;
                            mulStart  = 1'b1;
                            mulSigned = opSigned;
                            cnt_d     = CNT_LOAD;
                            isAcc_d   = (ex_op >= OP_MADD);
                            isSub_d   = (ex_op == OP_MSUB) || (ex_op == OP_MSUBU);
                            stall     = 1'b1;
                            state_d   = MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Division by zero is architecturally undefined:
                            // nothing is started and HI/LO stay untouched.
                            if (ex_srcb != '0) begin
                                opA_d     = ex_srca;
                                opB_d     = ex_srcb;
                                divStart  = 1'b1;
                                divSigned = opSigned;
                                stall     = 1'b1;
                                state_d   = DIV_WAIT;
                            end
                        end
                        OP_MTHI: begin
                            hiWe    = 1'b1;
                            hiWdata = ex_srca;
                        end
                        OP_MTLO: begin
                            loWe    = 1'b1;
                            loWdata = ex_srca;
                        end
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                stall = 1'b1;
                // The counter reaches zero exactly in the cycle the
                // multiplier presents the product.
                if (cnt_q == '0) begin
                    prod_d = mul_res;
                    if (!isAcc_q) begin
                        res_d = mul_res;
                    end
                    state_d = isAcc_q ? ACC : DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACC: begin
                stall   = 1'b1;
                res_d   = isSub_q ? (hiLo - prod_q) : (hiLo + prod_q);
                state_d = DONE;
            end
            DIV_WAIT: begin
                stall = 1'b1;
                if (div_done) begin
                    res_d   = {div_rem, div_quot};
                    state_d = DONE;
                end
            end
            DONE: begin
                // EXE advances this cycle; the instruction still in EXE is the
                // one that was just completed, so it is not looked at again.
                hiWe    = 1'b1;
                loWe    = 1'b1;
                hiWdata = res_q[63:32];
                loWdata = res_q[31:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush wins over everything: drop the operation, write nothing,
        // release EXE and cancel the divider if it is running.
        if (ex_flush) begin
            state_d  = IDLE;
            hiWe     = 1'b0;
            loWe     = 1'b0;
            stall    = 1'b0;
            divAbort = (state_q == DIV_WAIT);
        end
    end

    always_comb begin
        mul_start  = 1'b0;
        mul_signed = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_abort  = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hi_wdata   = '0;
        lo_wdata   = '0;
        ex_stall   = 1'b0;
        if (resetn) begin
            mul_start  = mulStart;
            mul_signed = mulSigned;
            div_start  = divStart;
            div_signed = divSigned;
            div_abort  = divAbort;
            hi_we      = hiWe;
            lo_we      = loWe;
            hi_wdata   = hiWdata;
            lo_wdata   = loWdata;
            ex_stall   = stall;
        end
    end

    assign busy = resetn && (state_q != IDLE);
    assign op_a = opA_q;
    assign op_b = opB_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
//------------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Directed bench for muldiv_ctrl. Stimulus pushes the expected HI/LO write
// for each operation into a queue; a monitor pops and compares whenever the
// controller drives a write enable. External multiplier, divider and HI/LO
// register models surround the controller.
//------------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exValid, exFlush;
    logic [3:0]  exOp;
    logic [31:0] exSrcA, exSrcB;
    logic [31:0] opA, opB;
    logic        mulStart, mulSigned;
    logic [63:0] mulRes;
    logic        divStart, divSigned, divAbort, divDone;
    logic [31:0] divQuot, divRem;
    logic [31:0] hiReg = 32'h0;
    logic [31:0] loReg = 32'h0;
    logic        hiWe, loWe;
    logic [31:0] hiWdata, loWdata;
    logic        exStall, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        hiWe;
        logic        loWe;
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } expT;

    expT expQ[$];

    int   writeCount = 0;
    int   mulStarts = 0, divStarts = 0, divAborts = 0, stallCycles = 0;
    logic mulSignedLast = 1'b0, divSignedLast = 1'b0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ex_valid   (exValid),
        .ex_op      (exOp),
        .ex_flush   (exFlush),
        .ex_srca    (exSrcA),
        .ex_srcb    (exSrcB),
        .op_a       (opA),
        .op_b       (opB),
        .mul_start  (mulStart),
        .mul_signed (mulSigned),
        .mul_res    (mulRes),
        .div_start  (divStart),
        .div_signed (divSigned),
        .div_abort  (divAbort),
        .div_done   (divDone),
        .div_quot   (divQuot),
        .div_rem    (divRem),
        .hi_q       (hiReg),
        .lo_q       (loReg),
        .hi_we      (hiWe),
        .lo_we      (loWe),
        .hi_wdata   (hiWdata),
        .lo_wdata   (loWdata),
        .ex_stall   (exStall),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // HI/LO architectural registers
    always @(posedge clk) begin
        if (hiWe) hiReg <= hiWdata;
        if (loWe) loReg <= loWdata;
    end

    // Two-stage pipelined multiplier; idle slots carry garbage so a capture
    // on the wrong cycle shows up in the result.
    function automatic logic [63:0] mulModel(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        sa = s ? {{32{a[31]}}, a} : {32'h0, a};
        sb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return 64'(sa * sb);
    endfunction

    logic [63:0] mulPipe1 = 64'h0, mulPipe2 = 64'h0;
    always @(posedge clk) begin
        mulPipe1 <= mulStart ? mulModel(exSrcA, exSrcB, mulSigned) : 64'hDEADBEEF_DEADBEEF;
        mulPipe2 <= mulPipe1;
    end
    assign mulRes = mulPipe2;

    // Iterative divider: done in the 4th cycle after div_start
    int          divCnt = 0;
    logic [31:0] dvA = 32'h0, dvB = 32'h1;
    logic        dvSigned = 1'b0;
    logic        divDoneForce = 1'b0;
    always @(posedge clk) begin
        if (divAbort) begin
            divCnt <= 0;
        end else if (divStart) begin
            divCnt   <= 4;
            dvA      <= exSrcA;
            dvB      <= exSrcB;
            dvSigned <= divSigned;
        end else if (divCnt != 0) begin
            divCnt <= divCnt - 1;
        end
    end
    assign divDone = (divCnt == 1) || divDoneForce;

    always_comb begin
        divQuot = 32'h0;
        divRem  = 32'h0;
        if (dvB != 32'h0) begin
            if (dvSigned) begin
                divQuot = $signed(dvA) / $signed(dvB);
                divRem  = $signed(dvA) % $signed(dvB);
            end else begin
                divQuot = dvA / dvB;
                divRem  = dvA % dvB;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic hw, input logic lw, input logic [31:0] hi,
                              input logic [31:0] lo, input string tag);
        expT e;
        e.hiWe = hw;
        e.loWe = lw;
        e.hi   = hi;
        e.lo   = lo;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    // Monitor: scoreboard compare on every HI/LO write, plus event counters
    always @(negedge clk) begin
        if (hiWe || loWe) begin
            writeCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got hi_we=%0b lo_we=%0b hi=%h lo=%h, required no write",
                         hiWe, loWe, hiWdata, loWdata);
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput({e.tag, "_we"}, {62'h0, hiWe, loWe}, {62'h0, e.hiWe, e.loWe});
                if (e.hiWe) checkOutput({e.tag, "_hi"}, {32'h0, hiWdata}, {32'h0, e.hi});
                if (e.loWe) checkOutput({e.tag, "_lo"}, {32'h0, loWdata}, {32'h0, e.lo});
            end
        end
        if (mulStart || divStart) begin
            checkOutput("start_exclusive", {63'h0, mulStart && divStart}, 64'h0);
        end
        if (mulStart) begin
            mulStarts++;
            mulSignedLast = mulSigned;
        end
        if (divStart) begin
            divStarts++;
            divSignedLast = divSigned;
        end
        if (divAbort) divAborts++;
        if (exStall)  stallCycles++;
    end

    // Present one instruction and hold it in EXE until the stall drops.
    // Entered and left just after a rising edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int stalls);
        bit done;
        done    = 1'b0;
        stalls  = 0;
        exValid = 1'b1;
        exOp    = op;
        exSrcA  = a;
        exSrcB  = b;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!exStall) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall_timeout: got ex_stall stuck high, required release within 40 cycles");
        end
        @(posedge clk);
        #1;
        exValid = 1'b0;
        exOp    = 4'd0;
    endtask

    initial begin
        int st;
        int snapA, snapB, snapC;

        resetn  = 1'b0;
        exValid = 1'b0;
        exFlush = 1'b0;
        exOp    = 4'd0;
        exSrcA  = 32'h0;
        exSrcB  = 32'h0;

        // Reset state
        #2;
        checkOutput("rst_busy", {63'h0, busy}, 64'h0);
        checkOutput("rst_stall", {63'h0, exStall}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("rst_op_a", {32'h0, opA}, 64'h0);
        checkOutput("rst_op_b", {32'h0, opB}, 64'h0);
        checkOutput("rst_outputs", {58'h0, mulStart, divStart, divAbort, hiWe, loWe, exStall}, 64'h0);
        @(posedge clk);
        #1;

        // MULT -3 * 5
        pushExpect(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
        applyStimulus(4'd1, 32'hFFFFFFFD, 32'd5, st);
        checkOutput("mult_stalls", 64'(st), 64'd3);
        checkOutput("mult_signed", {63'h0, mulSignedLast}, 64'h1);
        checkOutput("mult_op_a", {32'h0, opA}, 64'h0000_0000_FFFF_FFFD);
        checkOutput("mult_op_b", {32'h0, opB}, 64'd5);

        // DIVU 100 / 7, then DIV -7 / 2
        pushExpect(1'b1, 1'b1, 32'd2, 32'd14, "divu");
        applyStimulus(4'd4, 32'd100, 32'd7, st);
        checkOutput("divu_stalls", 64'(st), 64'd5);
        checkOutput("divu_signed", {63'h0, divSignedLast}, 64'h0);
        pushExpect(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, st);
        checkOutput("div_signed", {63'h0, divSignedLast}, 64'h1);

        // HI=0, LO=FFFFFFFF, then MADDU 1x1 and MSUBU 1x1
        pushExpect(1'b1, 1'b0, 32'h0, 32'h0, "mthi0");
        applyStimulus(4'd9, 32'h0, 32'h0, st);
        pushExpect(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, "mtlo_ones");
        applyStimulus(4'd10, 32'hFFFFFFFF, 32'h0, st);
        pushExpect(1'b1, 1'b1, 32'h1, 32'h0, "maddu");
        applyStimulus(4'd6, 32'd1, 32'd1, st);
        checkOutput("maddu_stalls", 64'(st), 64'd4);
        pushExpect(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, "msubu");
        applyStimulus(4'd8, 32'd1, 32'd1, st);
        checkOutput("msubu_stalls", 64'(st), 64'd4);

        // DIV 50/3 flushed in its second DIV_WAIT cycle
        snapA   = divAborts;
        snapB   = writeCount;
        exValid = 1'b1;
        exOp    = 4'd3;
        exSrcA  = 32'd50;
        exSrcB  = 32'd3;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        exFlush = 1'b1;
        @(negedge clk);
        checkOutput("flush_div_abort", {63'h0, divAbort}, 64'h1);
        checkOutput("flush_div_stall", {63'h0, exStall}, 64'h0);
        @(posedge clk);
        #1;
        exFlush = 1'b0;
        exValid = 1'b0;
        exOp    = 4'd0;
        @(negedge clk);
        checkOutput("flush_div_idle", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        divDoneForce = 1'b1;
        @(negedge clk);
        checkOutput("late_done_idle", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        divDoneForce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("flush_abort_count", 64'(divAborts - snapA), 64'd1);
        checkOutput("flush_no_write", 64'(writeCount - snapB), 64'd0);

        pushExpect(1'b1, 1'b1, 32'h0, 32'h2A, "mult_after_abort");
        applyStimulus(4'd1, 32'd7, 32'd6, st);
        checkOutput("mult_after_abort_stalls", 64'(st), 64'd3);

        // Back-to-back MTHI/MTLO, then DIV by zero
        snapA = stallCycles;
        pushExpect(1'b1, 1'b0, 32'h12345678, 32'h0, "mthi");
        applyStimulus(4'd9, 32'h12345678, 32'h0, st);
        pushExpect(1'b0, 1'b1, 32'h0, 32'h9ABCDEF0, "mtlo");
        applyStimulus(4'd10, 32'h9ABCDEF0, 32'h0, st);
        checkOutput("mt_no_stall", 64'(stallCycles - snapA), 64'd0);

        snapA = divStarts;
        snapB = writeCount;
        snapC = stallCycles;
        applyStimulus(4'd3, 32'd9, 32'd0, st);
        checkOutput("div0_no_start", 64'(divStarts - snapA), 64'd0);
        checkOutput("div0_no_write", 64'(writeCount - snapB), 64'd0);
        checkOutput("div0_no_stall", 64'(stallCycles - snapC), 64'd0);
        checkOutput("div0_hi_kept", {32'h0, hiReg}, 64'h12345678);

        // Flush coinciding with the DONE cycle of a MULT
        exValid = 1'b1;
        exOp    = 4'd1;
        exSrcA  = 32'd2;
        exSrcB  = 32'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        exFlush = 1'b1;
        @(negedge clk);
        checkOutput("flush_done_busy", {63'h0, busy}, 64'h1);
        checkOutput("flush_done_we", {62'h0, hiWe, loWe}, 64'h0);
        checkOutput("flush_done_stall", {63'h0, exStall}, 64'h0);
        @(posedge clk);
        #1;
        exFlush = 1'b0;
        exValid = 1'b0;
        exOp    = 4'd0;
        @(negedge clk);
        checkOutput("flush_done_idle", {63'h0, busy}, 64'h0);
        checkOutput("flush_done_hi", {32'h0, hiReg}, 64'h12345678);
        checkOutput("flush_done_lo", {32'h0, loReg}, 64'h9ABCDEF0);
        @(posedge clk);
        #1;

        // Reset asserted in MUL_WAIT
        exValid = 1'b1;
        exOp    = 4'd1;
        exSrcA  = 32'd4;
        exSrcB  = 32'd4;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_outputs", {57'h0, mulStart, divStart, divAbort, hiWe, loWe, exStall, busy}, 64'h0);
        checkOutput("midrst_op_a", {32'h0, opA}, 64'h0);
        exValid = 1'b0;
        exOp    = 4'd0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("midrst_idle", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;

        pushExpect(1'b1, 1'b1, 32'h1, 32'hFFFFFFFE, "multu_after_rst");
        applyStimulus(4'd2, 32'hFFFFFFFF, 32'd2, st);
        checkOutput("multu_signed", {63'h0, mulSignedLast}, 64'h0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000 time units");
        $fatal(1);
    end

endmodule
